dom_share_encoder: RTL

DOM_SHARE_ENCODER -- requirements
Module: dom_share_encoder

---
 rtl/dom_share_encoder_pkg.sv | 15 +
 rtl/dom_share_encoder_if.sv | 32 +++
 rtl/dom_share_encoder_share_reg.sv | 26 ++
 rtl/dom_share_encoder.sv | 117 +++++++++++
 4 files changed

// File: rtl/dom_share_encoder_pkg.sv
// rtl/dom_share_encoder_pkg.sv - shared types and defaults for the DOM share encoder
// Purpose : FSM state enum and default widths used by the encoder, its
//           share-register sub-module and its bus interface.
package dom_share_encoder_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAND = 2'd1,
      OUT  = 2'd2
   } state_t;

endpackage

// File: rtl/dom_share_encoder_if.sv
// rtl/dom_share_encoder_if.sv - handshake bundle for the DOM share encoder
// Purpose : groups the plaintext, randomness and share-pair handshakes.
// Modports: master - the environment side (drives plaintext, masks, o_ready)
//           slave  - the encoder side (drives readies, shares, valid, count)
interface dom_share_encoder_if
   import dom_share_encoder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
);
   logic [WIDTH-1:0] io_in_data;
   logic             io_in_valid;
   logic             io_in_ready;
   logic [WIDTH-1:0] p_rand;
   logic             p_rand_valid;
   logic             p_rand_ready;
   logic [WIDTH-1:0] io_o_s0;
   logic [WIDTH-1:0] io_o_s1;
   logic             io_o_valid;
   logic             io_o_ready;
   logic [CNT_W-1:0] io_cnt;

   modport master (
      output io_in_data, io_in_valid, p_rand, p_rand_valid, io_o_ready,
      input  io_in_ready, p_rand_ready, io_o_s0, io_o_s1, io_o_valid, io_cnt
   );

   modport slave (
      input  io_in_data, io_in_valid, p_rand, p_rand_valid, io_o_ready,
      output io_in_ready, p_rand_ready, io_o_s0, io_o_s1, io_o_valid, io_cnt
   );
endinterface

// File: rtl/dom_share_encoder_share_reg.sv
// rtl/dom_share_encoder_share_reg.sv - one share register (dom_share_reg)
// Purpose : WIDTH-bit register with load enable and asynchronous active-low
//           clear; each share lives in its own instance so shares never meet
//           in common logic.
// Ports   : clk, rst_n (async clear), ld (load enable), d (next value), q (share)
module dom_share_reg
   import dom_share_encoder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (ld) begin
         q <= d;
      end
   end

endmodule

// File: rtl/dom_share_encoder.sv
// rtl/dom_share_encoder.sv - first-order DOM share encoder (plaintext -> two shares)
// Purpose : accepts a plaintext word, waits for one fresh mask, emits the
//           registered share pair (data^mask, mask) and counts delivered pairs.
// Ports   : clock_0, reset_0 (async active-low)
//           io_in_data/io_in_valid/io_in_ready   plaintext handshake
//           p_rand/p_rand_valid/p_rand_ready     mask handshake
//           io_o_s0/io_o_s1/io_o_valid/io_o_ready share-pair handshake
//           io_cnt                               delivered pairs, wraps silently
module dom_share_encoder
   import dom_share_encoder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clock_0,
   input  logic             reset_0,
   input  logic [WIDTH-1:0] io_in_data,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] p_rand,
   input  logic             p_rand_valid,
   output logic             p_rand_ready,
   output logic [WIDTH-1:0] io_o_s0,
   output logic [WIDTH-1:0] io_o_s1,
   output logic             io_o_valid,
   input  logic             io_o_ready,
   output logic [CNT_W-1:0] io_cnt
);

   state_t           state_q;
   state_t           state_d;
   logic             alive_q;
   logic [WIDTH-1:0] plain_q;
   logic [WIDTH-1:0] s0_q;
   logic [WIDTH-1:0] s1_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept;
   logic             take_mask;
   logic             deliver;

   assign accept    = io_in_ready & io_in_valid;
   assign take_mask = p_rand_ready & p_rand_valid;
   assign deliver   = io_o_valid & io_o_ready;

   // alive_q keeps io_in_ready low through reset and sets on the first edge after it.
   always_ff @(posedge clock_0 or negedge reset_0) begin
      if (!reset_0) begin
         state_q <= IDLE;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = RAND;
         RAND:    if (take_mask) state_d = OUT;
         OUT:     if (deliver)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      io_in_ready  = 1'b0;
      p_rand_ready = 1'b0;
      io_o_valid   = 1'b0;
      case (state_q)
         IDLE:    io_in_ready  = alive_q;
         RAND:    p_rand_ready = 1'b1;
         OUT:     io_o_valid   = 1'b1;
         default: ;
      endcase
   end

   // Plaintext is wiped as soon as the mask is applied so it never lingers next to s1.
   always_ff @(posedge clock_0 or negedge reset_0) begin
      if (!reset_0) begin
         plain_q <= '0;
      end else if (accept) begin
         plain_q <= io_in_data;
      end else if (take_mask) begin
         plain_q <= '0;
      end
   end

   always_ff @(posedge clock_0 or negedge reset_0) begin
      if (!reset_0) begin
         cnt_q <= '0;
      end else if (deliver) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   dom_share_reg #(.WIDTH(WIDTH)) u_s0 (
      .clk   (clock_0),
      .rst_n (reset_0),
      .ld    (take_mask),
      .d     (plain_q ^ p_rand),
      .q     (s0_q)
   );

   dom_share_reg #(.WIDTH(WIDTH)) u_s1 (
      .clk   (clock_0),
      .rst_n (reset_0),
      .ld    (take_mask),
      .d     (p_rand),
      .q     (s1_q)
   );

   assign io_o_s0 = s0_q;
   assign io_o_s1 = s1_q;
   assign io_cnt  = cnt_q;

endmodule
